// File: rtl/iob_post_fifo.sv
// iob_post_fifo
//   Posted-write queue between the FSB I/O slave and the IOB bus master.
//   DEPTH entries of {address, data, byte strobes, R/W} are kept in a
//   circular buffer. Writes are acknowledged as soon as they are queued and
//   drained in order. Reads are non-posted: they are accepted only into an
//   empty queue and block further requests until their IOB completion
//   returns on o_rdv. Bus errors on already-acknowledged writes set the
//   sticky o_wberr flag.
//
//   Optional feature: define IOB_POST_MERGE_EN to let a write merge into
//   the tail entry (same address, non-overlapping strobes) instead of
//   consuming a new entry.
//
// Ports
//   i_clk, i_res        clock, asynchronous active-high reset
//   i_reqv .. i_requ    slave request (valid, R/W, word address, data, strobes)
//   o_reqrdy            request accepted at the next edge (qualified by i_reqv)
//   o_rdv/o_rdd/o_rderr read completion pulse, data and bus-error flag
//   o_ioreq .. o_iou    IOB master request and head-entry fields
//   i_ioact             master has taken the request
//   i_iodone/i_ioberr/i_iordd   master cycle finished, error, read data
//   o_wberr, i_berrclr  sticky posted-write error and its clear
//   o_empty/o_full/o_count      registered occupancy status

module iob_post_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 23,
    parameter int DW    = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_reqv,
    output logic          o_reqrdy,
    input  logic          i_reqrw,
    input  logic [AW:1]   i_reqa,
    input  logic [DW-1:0] i_reqd,
    input  logic          i_reql,
    input  logic          i_requ,
    output logic          o_rdv,
    output logic [DW-1:0] o_rdd,
    output logic          o_rderr,
    output logic          o_ioreq,
    output logic          o_iorw,
    output logic [AW:1]   o_ioa,
    output logic [DW-1:0] o_iod,
    output logic          o_iol,
    output logic          o_iou,
    input  logic          i_ioact,
    input  logic          i_iodone,
    input  logic          i_ioberr,
    input  logic [DW-1:0] i_iordd,
    output logic          o_wberr,
    input  logic          i_berrclr,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HB = DW / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;

    logic [AW:1]   r_a [DEPTH];
    logic [DW-1:0] r_d [DEPTH];
    logic [DEPTH-1:0] r_l, r_u, r_rw;

    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          r_empty, r_full;
    logic          r_rdpend;
    logic          r_rdv, r_rderr, r_wberr;
    logic [DW-1:0] r_rdd;
    logic [1:0]    r_state;

    logic          w_merge, w_accept, w_push, w_pop, w_head_rw;
    logic [CW-1:0] w_count_nxt;

`ifdef IOB_POST_MERGE_EN
    logic [PW-1:0] w_tail;
    logic          w_tail_busy;

    assign w_tail      = r_wp - 1'b1;
    // The tail is frozen once the master has been offered it as the head.
    assign w_tail_busy = (w_tail == r_rp) && (r_state != S_IDLE);
    assign w_merge     = !r_empty && !i_reqrw && !r_rw[w_tail] && !w_tail_busy
                         && (i_reqa == r_a[w_tail])
                         && !(i_reql && r_l[w_tail]) && !(i_requ && r_u[w_tail]);
`else
    assign w_merge = 1'b0;
`endif

    // Reads only enter an empty queue so they can never overtake posted writes.
    assign o_reqrdy  = i_reqv && !r_rdpend && (i_reqrw ? r_empty : (!r_full || w_merge));
    assign w_accept  = o_reqrdy;
    assign w_push    = w_accept && !w_merge;
    assign w_pop     = (r_state == S_ACT) && i_iodone;
    assign w_head_rw = r_rw[r_rp];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_a[i] <= '0;
                r_d[i] <= '0;
            end
            r_l  <= '0;
            r_u  <= '0;
            r_rw <= '0;
        end else begin
            if (w_push) begin
                r_a[r_wp]  <= i_reqa;
                r_d[r_wp]  <= i_reqd;
                r_l[r_wp]  <= i_reql;
                r_u[r_wp]  <= i_requ;
                r_rw[r_wp] <= i_reqrw;
            end
`ifdef IOB_POST_MERGE_EN
            if (w_accept && w_merge) begin
                if (i_reql) r_d[w_tail][HB-1:0]  <= i_reqd[HB-1:0];
                if (i_requ) r_d[w_tail][DW-1:HB] <= i_reqd[DW-1:HB];
                r_l[w_tail] <= r_l[w_tail] | i_reql;
                r_u[w_tail] <= r_u[w_tail] | i_requ;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_rdpend <= 1'b0;
            r_rdv    <= 1'b0;
            r_rdd    <= '0;
            r_rderr  <= 1'b0;
            r_wberr  <= 1'b0;
            r_state  <= S_IDLE;
        end else begin
            // Pointers wrap silently: DEPTH is a power of two.
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));

            r_rdv <= w_pop && w_head_rw;
            if (w_pop && w_head_rw) begin
                r_rdd    <= i_iordd;
                r_rderr  <= i_ioberr;
                r_rdpend <= 1'b0;
            end else if (w_accept && i_reqrw) begin
                r_rdpend <= 1'b1;
            end

            // A new error wins over a simultaneous clear.
            if (w_pop && !w_head_rw && i_ioberr)
                r_wberr <= 1'b1;
            else if (i_berrclr)
                r_wberr <= 1'b0;

            case (r_state)
                S_IDLE:  if (!r_empty) r_state <= S_REQ;
                S_REQ:   if (i_ioact)  r_state <= S_ACT;
                S_ACT:   if (i_iodone) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ioreq = (r_state == S_REQ);
    assign o_iorw  = r_rw[r_rp];
    assign o_ioa   = r_a[r_rp];
    assign o_iod   = r_d[r_rp];
    assign o_iol   = r_l[r_rp];
    assign o_iou   = r_u[r_rp];
    assign o_rdv   = r_rdv;
    assign o_rdd   = r_rdd;
    assign o_rderr = r_rderr;
    assign o_wberr = r_wberr;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: tb/tb_iob_post_fifo.sv
// Testbench for iob_post_fifo: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_iob_post_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int CW    = 3;

    logic          i_clk = 1'b0;
    logic          i_res;
    logic          i_reqv, i_reqrw, i_reql, i_requ;
    logic [AW:1]   i_reqa;
    logic [DW-1:0] i_reqd;
    logic          o_reqrdy, o_rdv, o_rderr, o_ioreq, o_iorw, o_iol, o_iou;
    logic [DW-1:0] o_rdd, o_iod;
    logic [AW:1]   o_ioa;
    logic          i_ioact, i_iodone, i_ioberr, i_berrclr;
    logic [DW-1:0] i_iordd;
    logic          o_wberr, o_empty, o_full;
    logic [CW-1:0] o_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW:1]   a;
        logic [DW-1:0] d;
        logic          l;
        logic          u;
        logic          rw;
    } ent_t;

    always #5 i_clk = ~i_clk;

    iob_post_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_res(i_res),
        .i_reqv(i_reqv), .o_reqrdy(o_reqrdy), .i_reqrw(i_reqrw),
        .i_reqa(i_reqa), .i_reqd(i_reqd), .i_reql(i_reql), .i_requ(i_requ),
        .o_rdv(o_rdv), .o_rdd(o_rdd), .o_rderr(o_rderr),
        .o_ioreq(o_ioreq), .o_iorw(o_iorw), .o_ioa(o_ioa), .o_iod(o_iod),
        .o_iol(o_iol), .o_iou(o_iou),
        .i_ioact(i_ioact), .i_iodone(i_iodone), .i_ioberr(i_ioberr), .i_iordd(i_iordd),
        .o_wberr(o_wberr), .i_berrclr(i_berrclr),
        .o_empty(o_empty), .o_full(o_full), .o_count(o_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_reqv = 0; i_reqrw = 0; i_reqa = '0; i_reqd = '0; i_reql = 0; i_requ = 0;
        i_ioact = 0; i_iodone = 0; i_ioberr = 0; i_iordd = '0; i_berrclr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_res = 1;
        tick();
        tick();
        i_res = 0;
        tick();
    endtask

    task automatic wait_ioreq(output bit ok);
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            if (o_ioreq) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", o_empty); end
        n_cmp++; if ({o_full, o_ioreq, o_rdv, o_wberr, o_reqrdy, o_rderr} !== 6'b0) begin
            n_err++; $display("FAIL rst_flags got=%b exp=000000", {o_full, o_ioreq, o_rdv, o_wberr, o_reqrdy, o_rderr}); end
        n_cmp++; if ({o_ioa, o_iod, o_rdd} !== '0) begin
            n_err++; $display("FAIL rst_buses got ioa=%h iod=%h rdd=%h exp=0", o_ioa, o_iod, o_rdd); end
        // queue three writes, put the head in flight, then reset
        for (int i = 0; i < 3; i++) begin
            i_reqv = 1; i_reqrw = 0; i_reqa = AW'(i + 1); i_reqd = 16'(i * 3 + 7); i_reql = 1; i_requ = 1;
            tick();
        end
        i_reqv = 0;
        wait_ioreq(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_ioreq_timeout got=0 exp=1"); end
        i_ioact = 1;
        tick();
        i_ioact = 0;
        n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count got=%0d exp=3", o_count); end
        i_res = 1;
        #1;
        n_cmp++; if ({o_ioreq, o_count, o_empty} !== {1'b0, 3'd0, 1'b1}) begin
            n_err++; $display("FAIL rst_async got ioreq=%b count=%0d empty=%b exp 0/0/1", o_ioreq, o_count, o_empty); end
        tick();
        i_res = 0;
        tick();
        i_iodone = 1;
        tick();
        i_iodone = 0;
        n_cmp++; if ({o_count, o_empty, o_rdv} !== {3'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL rst_late_done got count=%0d empty=%b rdv=%b exp 0/1/0", o_count, o_empty, o_rdv); end
        tick();
        n_cmp++; if (o_ioreq !== 1'b0) begin n_err++; $display("FAIL rst_late_ioreq got=%b exp=0", o_ioreq); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            i_reqv = 1; i_reqrw = 0; i_reqa = AW'(32'h100 + i); i_reqd = 16'($urandom); i_reql = 1; i_requ = 1;
            #1;
            n_cmp++; if (o_reqrdy !== (i < 4)) begin
                n_err++; $display("FAIL full_reqrdy_%0d got=%b exp=%b", i, o_reqrdy, (i < 4)); end
            if (i == 1) begin
                n_cmp++; if (o_ioreq !== 1'b0) begin n_err++; $display("FAIL latency_early got=%b exp=0", o_ioreq); end
            end
            if (i == 2) begin
                n_cmp++; if (o_ioreq !== 1'b1) begin n_err++; $display("FAIL latency_ioreq got=%b exp=1", o_ioreq); end
                n_cmp++; if (o_ioa !== 23'h100) begin n_err++; $display("FAIL latency_ioa got=%h exp=100", o_ioa); end
            end
            tick();
        end
        i_reqv = 0;
        n_cmp++; if ({o_full, o_count, o_empty} !== {1'b1, 3'd4, 1'b0}) begin
            n_err++; $display("FAIL full_status got full=%b count=%0d empty=%b exp 1/4/0", o_full, o_count, o_empty); end
    endtask

    task automatic test_read_stall();
        bit ok;
        do_reset();
        i_reqv = 1; i_reqrw = 0; i_reqa = 23'h7FFFF0; i_reqd = 16'h1234; i_reql = 1; i_requ = 1;
        tick();
        i_reqrw = 1; i_reqa = 23'h580000;
        #1;
        n_cmp++; if (o_reqrdy !== 1'b0) begin n_err++; $display("FAIL rd_blocked got=%b exp=0", o_reqrdy); end
        wait_ioreq(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_wr_ioreq_timeout got=0 exp=1"); end
        n_cmp++; if ({o_ioa, o_iod, o_iorw} !== {23'h7FFFF0, 16'h1234, 1'b0}) begin
            n_err++; $display("FAIL rd_wr_head got a=%h d=%h rw=%b exp 7ffff0/1234/0", o_ioa, o_iod, o_iorw); end
        i_ioact = 1;
        tick();
        i_ioact = 0;
        tick();
        n_cmp++; if (o_reqrdy !== 1'b0) begin n_err++; $display("FAIL rd_stall_act got=%b exp=0", o_reqrdy); end
        i_iodone = 1;
        tick();
        i_iodone = 0;
        n_cmp++; if (o_reqrdy !== 1'b1) begin n_err++; $display("FAIL rd_accept got=%b exp=1", o_reqrdy); end
        n_cmp++; if (o_rdv !== 1'b0) begin n_err++; $display("FAIL rd_wr_no_rdv got=%b exp=0", o_rdv); end
        tick();
        i_reqv = 0;
        wait_ioreq(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_ioreq_timeout got=0 exp=1"); end
        n_cmp++; if ({o_ioa, o_iorw} !== {23'h580000, 1'b1}) begin
            n_err++; $display("FAIL rd_head got a=%h rw=%b exp 580000/1", o_ioa, o_iorw); end
        i_reqv = 1; i_reqrw = 0;
        #1;
        n_cmp++; if (o_reqrdy !== 1'b0) begin n_err++; $display("FAIL rd_pend_blocks_wr got=%b exp=0", o_reqrdy); end
        i_reqv = 0;
        i_ioact = 1;
        tick();
        i_ioact = 0;
        i_iodone = 1; i_iordd = 16'hBEEF; i_ioberr = 0;
        tick();
        i_iodone = 0;
        n_cmp++; if ({o_rdv, o_rdd, o_rderr} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_err++; $display("FAIL rd_complete got rdv=%b rdd=%h err=%b exp 1/beef/0", o_rdv, o_rdd, o_rderr); end
        tick();
        n_cmp++; if (o_rdv !== 1'b0) begin n_err++; $display("FAIL rd_pulse got=%b exp=0", o_rdv); end
    endtask

    task automatic test_wberr();
        bit ok;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            i_reqv = 1; i_reqrw = 0; i_reqa = AW'(32'h42 + pass); i_reqd = 16'h5A5A; i_reql = 1; i_requ = 1;
            tick();
            i_reqv = 0;
            wait_ioreq(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL wberr_ioreq_timeout_%0d got=0 exp=1", pass); end
            i_ioact = 1;
            tick();
            i_ioact = 0;
            i_iodone = 1; i_ioberr = 1; i_berrclr = (pass == 1);
            tick();
            i_iodone = 0; i_ioberr = 0; i_berrclr = 0;
            n_cmp++; if ({o_wberr, o_rdv, o_empty} !== 3'b101) begin
                n_err++; $display("FAIL wberr_set_%0d got wberr=%b rdv=%b empty=%b exp 1/0/1", pass, o_wberr, o_rdv, o_empty); end
        end
        tick();
        n_cmp++; if ({o_wberr, o_rdv} !== 2'b10) begin
            n_err++; $display("FAIL wberr_sticky got wberr=%b rdv=%b exp 1/0", o_wberr, o_rdv); end
        i_berrclr = 1;
        tick();
        i_berrclr = 0;
        n_cmp++; if (o_wberr !== 1'b0) begin n_err++; $display("FAIL wberr_clr got=%b exp=0", o_wberr); end
    endtask

    task automatic test_wrap();
        logic [AW:1] pushed[$];
        logic [AW:1] seen[$];
        logic [31:0] r;
        int          max_cnt = 0;
        bit          acted = 0;
        do_reset();
        for (int cyc = 0; cyc < 300 && seen.size() < 10; cyc++) begin
            i_iodone = acted;
            i_ioact  = o_ioreq;
            if (o_ioreq) seen.push_back(o_ioa);
            if (pushed.size() < 10 && o_count < 3) begin
                r = $urandom;
                i_reqv = 1; i_reqrw = 0; i_reqa = {r[14:0], 8'(pushed.size())};
                i_reqd = 16'(r); i_reql = 1; i_requ = 1;
                #1;
                if (o_reqrdy) pushed.push_back(i_reqa);
            end else begin
                i_reqv = 0;
            end
            acted = o_ioreq;
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            tick();
        end
        idle_inputs();
        n_cmp++; if (seen.size() !== 10) begin n_err++; $display("FAIL wrap_drain got=%0d exp=10", seen.size()); end
        for (int i = 0; i < 10 && i < seen.size() && i < pushed.size(); i++) begin
            n_cmp++; if (seen[i] !== pushed[i]) begin
                n_err++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, seen[i], pushed[i]); end
        end
        n_cmp++; if (max_cnt > 3 || max_cnt < 1) begin
            n_err++; $display("FAIL wrap_occupancy got max=%0d exp 1..3", max_cnt); end
    endtask

    task automatic test_merge();
        do_reset();
        i_reqv = 1; i_reqrw = 0; i_reqa = 23'h155; i_reqd = 16'hAB00; i_reql = 0; i_requ = 1;
        tick();
        i_reqd = 16'h00CD; i_reql = 1; i_requ = 0;
        #1;
        n_cmp++; if (o_reqrdy !== 1'b1) begin n_err++; $display("FAIL merge_reqrdy got=%b exp=1", o_reqrdy); end
        tick();
        i_reqv = 0;
        tick();
`ifdef IOB_POST_MERGE_EN
        n_cmp++; if ({o_count, o_iod, o_iol, o_iou} !== {3'd1, 16'hABCD, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL merge_result got count=%0d iod=%h l=%b u=%b exp 1/abcd/1/1", o_count, o_iod, o_iol, o_iou); end
`else
        n_cmp++; if ({o_count, o_iod, o_iol, o_iou} !== {3'd2, 16'hAB00, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL merge_result got count=%0d iod=%h l=%b u=%b exp 2/ab00/0/1", o_count, o_iod, o_iol, o_iou); end
`endif
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        bit          m_rdpend = 0, m_wberr = 0, m_act = 0;
        bit          e_rdv = 0, e_rderr = 0;
        logic [DW-1:0] e_rdd = '0;
        logic [31:0] r;
        bit          acc, pop, actn, erdy;
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            r = $urandom;
            i_ioact   = o_ioreq && r[0];
            i_iodone  = m_act ? (r[2:1] == 2'd0) : (r[5:3] == 3'd0);
            i_ioberr  = (r[8:6] == 3'd0);
            i_berrclr = (r[11:9] == 3'd0);
            i_reqv    = (cyc < 800) && r[12];
            i_reqrw   = (r[14:13] == 2'd0);
            i_reql    = r[15];
            i_requ    = r[16];
            i_iordd   = 16'($urandom);
            i_reqd    = 16'($urandom);
            r = $urandom;
            i_reqa    = {r[14:0], 8'(cyc)};
            #1;
            erdy = i_reqv && !m_rdpend && (i_reqrw ? (q.size() == 0) : (q.size() < DEPTH));
            n_cmp++; if (o_reqrdy !== erdy) begin n_err++; $display("FAIL rand_reqrdy cyc=%0d got=%b exp=%b", cyc, o_reqrdy, erdy); end
            n_cmp++; if (int'(o_count) !== q.size() || o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin
                n_err++; $display("FAIL rand_occupancy cyc=%0d got count=%0d empty=%b full=%b exp count=%0d", cyc, o_count, o_empty, o_full, q.size()); end
            n_cmp++; if (o_wberr !== m_wberr) begin n_err++; $display("FAIL rand_wberr cyc=%0d got=%b exp=%b", cyc, o_wberr, m_wberr); end
            n_cmp++; if (o_rdv !== e_rdv || (e_rdv && (o_rdd !== e_rdd || o_rderr !== e_rderr))) begin
                n_err++; $display("FAIL rand_rdv cyc=%0d got rdv=%b rdd=%h err=%b exp rdv=%b rdd=%h err=%b", cyc, o_rdv, o_rdd, o_rderr, e_rdv, e_rdd, e_rderr); end
            if (q.size() > 0) begin
                n_cmp++; if ({o_ioa, o_iod, o_iol, o_iou, o_iorw} !== q[0]) begin
                    n_err++; $display("FAIL rand_head cyc=%0d got a=%h d=%h rw=%b exp a=%h d=%h rw=%b", cyc, o_ioa, o_iod, o_iorw, q[0].a, q[0].d, q[0].rw); end
            end
            if (o_ioreq && (q.size() == 0 || m_act)) begin
                n_cmp++; n_err++; $display("FAIL rand_ioreq cyc=%0d got=1 exp=0", cyc);
            end
            acc  = erdy;
            pop  = i_iodone && m_act;
            actn = i_ioact && o_ioreq && !m_act;
            @(posedge i_clk);
            e_rdv = 0;
            if (pop) begin
                e = q.pop_front();
                if (e.rw) begin
                    e_rdv = 1; e_rdd = i_iordd; e_rderr = i_ioberr; m_rdpend = 0;
                end
            end
            if (pop && !e.rw && i_ioberr) m_wberr = 1;
            else if (i_berrclr) m_wberr = 0;
            if (acc) begin
                q.push_back({i_reqa, i_reqd, i_reql, i_requ, i_reqrw});
                if (i_reqrw) m_rdpend = 1;
            end
            m_act = pop ? 1'b0 : (m_act || actn);
            #1;
        end
        idle_inputs();
        n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rand_drained got empty=%b count=%0d exp empty=1", o_empty, o_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        i_res = 1;
        test_reset();
        test_full();
        test_read_stall();
        test_wberr();
        test_wrap();
        test_merge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
